// File: rtl/mmio_bus_decoder_if.sv
// Bus bundle between the CPU memory port, the MMIO decoder and its slave devices.
//   cpu_valid/cpu_addr/cpu_wstrb/cpu_wdata : CPU request (wstrb all-zero = read)
//   cpu_ready/cpu_rdata/cpu_fault          : one-cycle completion from the decoder
//   s_valid/s_addr/s_wstrb/s_wdata         : registered request fanned out to slaves
//   s_ready/s_rdata                        : per-slave completion and read data
// Modports:
//   slave  : the decoder (receives CPU requests, drives the slave request bus)
//   master : the environment (CPU side plus slave devices)
interface mmio_bus_decoder_if #(
    parameter int unsigned NUM_SLAVES = 8,
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32
);
    logic                         cpu_valid;
    logic [ADDR_W-1:0]            cpu_addr;
    logic [DATA_W/8-1:0]          cpu_wstrb;
    logic [DATA_W-1:0]            cpu_wdata;
    logic                         cpu_ready;
    logic [DATA_W-1:0]            cpu_rdata;
    logic                         cpu_fault;
    logic [NUM_SLAVES-1:0]        s_valid;
    logic [ADDR_W-1:0]            s_addr;
    logic [DATA_W/8-1:0]          s_wstrb;
    logic [DATA_W-1:0]            s_wdata;
    logic [NUM_SLAVES-1:0]        s_ready;
    logic [NUM_SLAVES*DATA_W-1:0] s_rdata;

    modport slave (
        input  cpu_valid, cpu_addr, cpu_wstrb, cpu_wdata,
        output cpu_ready, cpu_rdata, cpu_fault,
        output s_valid, s_addr, s_wstrb, s_wdata,
        input  s_ready, s_rdata
    );

    modport master (
        output cpu_valid, cpu_addr, cpu_wstrb, cpu_wdata,
        input  cpu_ready, cpu_rdata, cpu_fault,
        input  s_valid, s_addr, s_wstrb, s_wdata,
        output s_ready, s_rdata
    );
endinterface

// File: rtl/mmio_bus_decoder.sv
// Table-driven MMIO address decoder and response mux.
// A CPU request sampled in IDLE is matched against NUM_SLAVES base/mask windows (lowest
// index wins), registered onto the broadcast slave bus with a one-hot s_valid, and the
// selected slave's completion is returned to the CPU as a one-cycle cpu_ready pulse.
// Unmapped or timed-out accesses complete with cpu_fault=1 and ERR_RDATA.
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   bus         : CPU request/response and slave request/response bundle (slave modport)
//   fault_addr  : address of the most recent faulting access
//   fault_count : saturating count of faulting accesses
module mmio_bus_decoder #(
    parameter int unsigned                  NUM_SLAVES     = 8,
    parameter int unsigned                  ADDR_W         = 32,
    parameter int unsigned                  DATA_W         = 32,
    parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_BASE     = '0,
    parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_MASK     = '0,
    parameter int unsigned                  TIMEOUT_CYCLES = 255,
    parameter logic [DATA_W-1:0]            ERR_RDATA      = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    mmio_bus_decoder_if.slave     bus,
    output logic [ADDR_W-1:0]     fault_addr,
    output logic [15:0]           fault_count
);

    localparam int unsigned StrbW = DATA_W / 8;
    // Keep the counter at least one bit wide even when the timeout is disabled.
    localparam int unsigned CntW  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYCLES);
    localparam bit TimeoutEn = (TIMEOUT_CYCLES != 0);

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StActive = 2'd1;
    localparam logic [1:0] StResp   = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [NUM_SLAVES-1:0] s_valid_q, s_valid_d;
    logic [ADDR_W-1:0]     s_addr_q, s_addr_d;
    logic [StrbW-1:0]      s_wstrb_q, s_wstrb_d;
    logic [DATA_W-1:0]     s_wdata_q, s_wdata_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [DATA_W-1:0]     res_rdata_q, res_rdata_d;
    logic                  res_fault_q, res_fault_d;
    logic                  cpu_ready_q, cpu_ready_d;
    logic [DATA_W-1:0]     cpu_rdata_q, cpu_rdata_d;
    logic                  cpu_fault_q, cpu_fault_d;
    logic [ADDR_W-1:0]     fault_addr_q, fault_addr_d;
    logic [15:0]           fault_count_q, fault_count_d;

    logic                  hit;
    logic [NUM_SLAVES-1:0] hit_onehot;
    logic                  sel_ready;
    logic [DATA_W-1:0]     sel_rdata;
    logic                  fault_evt;
    logic [ADDR_W-1:0]     fault_at;
    logic [CntW-1:0]       cnt_inc;

    // Parallel window match; scanning downwards lets the lowest matching slot win.
    always_comb begin
        hit        = 1'b0;
        hit_onehot = '0;
        for (int i = int'(NUM_SLAVES) - 1; i >= 0; i--) begin
            if ((bus.cpu_addr & SLAVE_MASK[i*ADDR_W +: ADDR_W]) ==
                SLAVE_BASE[i*ADDR_W +: ADDR_W]) begin
                hit           = 1'b1;
                hit_onehot    = '0;
                hit_onehot[i] = 1'b1;
            end
        end
    end

    // The held one-hot s_valid doubles as the selected-slot index, so ready from any
    // other slave is masked off here.
    always_comb begin
        sel_ready = |(bus.s_ready & s_valid_q);
        sel_rdata = '0;
        for (int i = 0; i < int'(NUM_SLAVES); i++) begin
            if (s_valid_q[i]) begin
                sel_rdata = bus.s_rdata[i*DATA_W +: DATA_W];
            end
        end
    end

    assign cnt_inc = cnt_q + CntW'(1);

    always_comb begin
        state_d       = state_q;
        s_valid_d     = s_valid_q;
        s_addr_d      = s_addr_q;
        s_wstrb_d     = s_wstrb_q;
        s_wdata_d     = s_wdata_q;
        cnt_d         = cnt_q;
        res_rdata_d   = res_rdata_q;
        res_fault_d   = res_fault_q;
        cpu_ready_d   = 1'b0;
        cpu_rdata_d   = '0;
        cpu_fault_d   = 1'b0;
        fault_addr_d  = fault_addr_q;
        fault_count_d = fault_count_q;
        fault_evt     = 1'b0;
        fault_at      = s_addr_q;

        unique case (state_q)
            StIdle: begin
                if (bus.cpu_valid) begin
                    s_addr_d  = bus.cpu_addr;
                    s_wstrb_d = bus.cpu_wstrb;
                    s_wdata_d = bus.cpu_wdata;
                    if (hit) begin
                        s_valid_d = hit_onehot;
                        cnt_d     = '0;
                        state_d   = StActive;
                    end else begin
                        // Unmapped: no slave ever sees the request.
                        res_rdata_d = ERR_RDATA;
                        res_fault_d = 1'b1;
                        fault_evt   = 1'b1;
                        fault_at    = bus.cpu_addr;
                        state_d     = StResp;
                    end
                end
            end
            StActive: begin
                // Ready is checked first so it wins over a coincident timeout.
                if (sel_ready) begin
                    res_rdata_d = sel_rdata;
                    res_fault_d = 1'b0;
                    s_valid_d   = '0;
                    state_d     = StResp;
                end else if (TimeoutEn) begin
                    if (cnt_inc == CntMax) begin
                        res_rdata_d = ERR_RDATA;
                        res_fault_d = 1'b1;
                        s_valid_d   = '0;
                        fault_evt   = 1'b1;
                        state_d     = StResp;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            StResp: begin
                cpu_ready_d = 1'b1;
                cpu_rdata_d = res_rdata_q;
                cpu_fault_d = res_fault_q;
                state_d     = StIdle;
            end
            default: begin
                s_valid_d = '0;
                state_d   = StIdle;
            end
        endcase

        if (fault_evt) begin
            fault_addr_d = fault_at;
            if (fault_count_q != 16'hFFFF) begin
                fault_count_d = fault_count_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StIdle;
            s_valid_q     <= '0;
            s_addr_q      <= '0;
            s_wstrb_q     <= '0;
            s_wdata_q     <= '0;
            cnt_q         <= '0;
            res_rdata_q   <= '0;
            res_fault_q   <= 1'b0;
            cpu_ready_q   <= 1'b0;
            cpu_rdata_q   <= '0;
            cpu_fault_q   <= 1'b0;
            fault_addr_q  <= '0;
            fault_count_q <= '0;
        end else begin
            state_q       <= state_d;
            s_valid_q     <= s_valid_d;
            s_addr_q      <= s_addr_d;
            s_wstrb_q     <= s_wstrb_d;
            s_wdata_q     <= s_wdata_d;
            cnt_q         <= cnt_d;
            res_rdata_q   <= res_rdata_d;
            res_fault_q   <= res_fault_d;
            cpu_ready_q   <= cpu_ready_d;
            cpu_rdata_q   <= cpu_rdata_d;
            cpu_fault_q   <= cpu_fault_d;
            fault_addr_q  <= fault_addr_d;
            fault_count_q <= fault_count_d;
        end
    end

    assign bus.cpu_ready = cpu_ready_q;
    assign bus.cpu_rdata = cpu_rdata_q;
    assign bus.cpu_fault = cpu_fault_q;
    assign bus.s_valid   = s_valid_q;
    assign bus.s_addr    = s_addr_q;
    assign bus.s_wstrb   = s_wstrb_q;
    assign bus.s_wdata   = s_wdata_q;
    assign fault_addr    = fault_addr_q;
    assign fault_count   = fault_count_q;

endmodule

// File: tb/tb_mmio_bus_decoder.sv
// Self-checking bench for mmio_bus_decoder: directed scenarios plus random traffic.
// Expected responses come from an address-window reference model and are queued at issue
// time; an independent monitor pops and compares whenever cpu_ready pulses.
module tb_mmio_bus_decoder;

    localparam int unsigned NS  = 4;
    localparam int unsigned TO  = 4;
    localparam logic [31:0] ERR = 32'hBAD0_BAD0;
    localparam logic [NS*32-1:0] BASE_P =
        {32'h2000_0000, 32'h1000_0000, 32'h2000_0000, 32'h3000_0000};
    localparam logic [NS*32-1:0] MASK_P =
        {32'hF000_0000, 32'hFFFF_FFF0, 32'hFFFF_FF00, 32'hFFFF_0000};

    logic [31:0] base_a [NS] = '{32'h3000_0000, 32'h2000_0000, 32'h1000_0000, 32'h2000_0000};
    logic [31:0] mask_a [NS] = '{32'hFFFF_0000, 32'hFFFF_FF00, 32'hFFFF_FFF0, 32'hF000_0000};

    typedef struct {
        logic [31:0] rdata;
        logic        fault;
        logic [31:0] faddr;
        logic [15:0] fcnt;
        int          rcyc;
        int          svc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] fault_addr;
    logic [15:0] fault_count;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Slave-model controls, set per transaction by the stimulus process.
    int          cur_lat   = 0;
    logic [31:0] cur_data  = '0;
    logic [NS-1:0] exp_onehot = '0;
    logic [31:0] exp_addr  = '0;
    logic [3:0]  exp_wstrb = '0;
    logic [31:0] exp_wdata = '0;
    bit          seen      = 1'b0;
    int          act       = 0;
    int          sv_cycles = 0;

    // Reference model state.
    logic [31:0] m_faddr = '0;
    logic [15:0] m_fcnt  = '0;
    exp_t        exp_q[$];

    mmio_bus_decoder_if #(.NUM_SLAVES(NS), .ADDR_W(32), .DATA_W(32)) bus ();

    mmio_bus_decoder #(
        .NUM_SLAVES     (NS),
        .ADDR_W         (32),
        .DATA_W         (32),
        .SLAVE_BASE     (BASE_P),
        .SLAVE_MASK     (MASK_P),
        .TIMEOUT_CYCLES (TO),
        .ERR_RDATA      (ERR)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .fault_addr  (fault_addr),
        .fault_count (fault_count)
    );

    initial forever #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act_v, input logic [63:0] exp_v);
        checks++;
        if (act_v !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act_v, exp_v, cyc);
        end
    endtask

    function automatic int decode(input logic [31:0] a);
        for (int i = 0; i < int'(NS); i++) begin
            if ((a & mask_a[i]) == base_a[i]) return i;
        end
        return -1;
    endfunction

    // Slave devices: selected slave answers after cur_lat wait cycles; others toggle
    // s_ready randomly to show non-selected ready is ignored.
    initial begin
        logic [NS-1:0]    noise;
        logic [NS-1:0]    rdy;
        logic [NS*32-1:0] rd;
        bus.s_ready = '0;
        bus.s_rdata = '0;
        forever begin
            @(negedge clk);
            noise = NS'($urandom);
            if (bus.s_valid != '0) begin
                if (!seen) begin
                    seen = 1'b1;
                    act  = 0;
                    chk("s_valid_onehot", 64'(bus.s_valid), 64'(exp_onehot));
                    chk("s_addr", 64'(bus.s_addr), 64'(exp_addr));
                    chk("s_wstrb", 64'(bus.s_wstrb), 64'(exp_wstrb));
                    chk("s_wdata", 64'(bus.s_wdata), 64'(exp_wdata));
                end
                sv_cycles++;
                rdy = noise & ~bus.s_valid;
                if (act == cur_lat) rdy = rdy | bus.s_valid;
                act++;
            end else begin
                rdy = noise;
            end
            for (int i = 0; i < int'(NS); i++) begin
                rd[i*32 +: 32] = bus.s_valid[i] ? cur_data : $urandom;
            end
            bus.s_ready = rdy;
            bus.s_rdata = rd;
        end
    end

    // Monitor: every cpu_ready pulse must match the oldest queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.cpu_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_cpu_ready", 64'(bus.cpu_ready), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("cpu_rdata", 64'(bus.cpu_rdata), 64'(e.rdata));
                    chk("cpu_fault", 64'(bus.cpu_fault), 64'(e.fault));
                    chk("ready_cycle", 64'(cyc), 64'(e.rcyc));
                    chk("s_valid_cycles", 64'(sv_cycles), 64'(e.svc));
                    chk("fault_addr", 64'(fault_addr), 64'(e.faddr));
                    chk("fault_count", 64'(fault_count), 64'(e.fcnt));
                end
            end
        end
    end

    task automatic do_txn(input logic [31:0] a, input logic [3:0] st, input logic [31:0] wd,
                          input int lat, input logic [31:0] dat);
        exp_t e;
        int   s;
        int   issue;
        bit   got;
        s = decode(a);
        @(negedge clk);
        issue = cyc + 1;
        if (s < 0) begin
            e.rdata = ERR; e.fault = 1'b1; e.rcyc = issue + 1; e.svc = 0;
        end else if (lat < int'(TO)) begin
            e.rdata = dat; e.fault = 1'b0; e.rcyc = issue + 2 + lat; e.svc = lat + 1;
        end else begin
            e.rdata = ERR; e.fault = 1'b1; e.rcyc = issue + int'(TO) + 1; e.svc = int'(TO);
        end
        if (e.fault) begin
            m_faddr = a;
            if (m_fcnt != 16'hFFFF) m_fcnt = m_fcnt + 16'd1;
        end
        e.faddr = m_faddr;
        e.fcnt  = m_fcnt;
        exp_q.push_back(e);

        cur_lat    = lat;
        cur_data   = dat;
        exp_onehot = '0;
        if (s >= 0) exp_onehot[s] = 1'b1;
        exp_addr   = a;
        exp_wstrb  = st;
        exp_wdata  = wd;
        seen       = 1'b0;
        sv_cycles  = 0;

        bus.cpu_valid = 1'b1;
        bus.cpu_addr  = a;
        bus.cpu_wstrb = st;
        bus.cpu_wdata = wd;
        got = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (bus.cpu_ready) begin
                got = 1'b1;
                break;
            end
            // Inputs other than the held valid must be ignored after IDLE.
            bus.cpu_addr  = $urandom;
            bus.cpu_wstrb = 4'($urandom);
            bus.cpu_wdata = $urandom;
        end
        bus.cpu_valid = 1'b0;
        if (!got) begin
            chk("cpu_ready_timeout", 64'(got), 64'd1);
            if (exp_q.size() != 0) void'(exp_q.pop_front());
        end
    endtask

    initial begin
        logic [31:0] a;
        int          cat;
        int          lat;
        reset         = 1'b1;
        bus.cpu_valid = 1'b0;
        bus.cpu_addr  = '0;
        bus.cpu_wstrb = '0;
        bus.cpu_wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("rst_cpu_ready", 64'(bus.cpu_ready), 64'd0);
        chk("rst_cpu_fault", 64'(bus.cpu_fault), 64'd0);
        chk("rst_cpu_rdata", 64'(bus.cpu_rdata), 64'd0);
        chk("rst_s_valid", 64'(bus.s_valid), 64'd0);
        chk("rst_s_addr", 64'(bus.s_addr), 64'd0);
        chk("rst_s_wstrb", 64'(bus.s_wstrb), 64'd0);
        chk("rst_s_wdata", 64'(bus.s_wdata), 64'd0);
        chk("rst_fault_addr", 64'(fault_addr), 64'd0);
        chk("rst_fault_count", 64'(fault_count), 64'd0);

        do_txn(32'h1000_0004, 4'h0, 32'h0, 0, 32'hDEAD_BEEF);   // mapped read, slot 2
        do_txn(32'h2000_0000, 4'hF, 32'h55, 1, 32'h0);          // overlap: slot 1 wins
        do_txn(32'hF000_0000, 4'h0, 32'h0, 0, 32'h0);           // unmapped
        do_txn(32'h3000_0010, 4'h0, 32'h0, 50, 32'h0);          // timeout
        do_txn(32'h3000_0014, 4'h0, 32'h0, 3, 32'h1234_5678);   // ready on the limit cycle
        do_txn(32'h2ABC_0000, 4'h3, 32'hCAFE, 2, 32'h0);        // slot 3 only

        // Reset during ACTIVE: access is abandoned, status cleared.
        @(negedge clk);
        cur_lat    = 1000;
        exp_onehot = 4'b0001;
        exp_addr   = 32'h3000_0020;
        exp_wstrb  = 4'h0;
        exp_wdata  = 32'h0;
        seen       = 1'b0;
        bus.cpu_valid = 1'b1;
        bus.cpu_addr  = 32'h3000_0020;
        bus.cpu_wstrb = 4'h0;
        bus.cpu_wdata = 32'h0;
        @(negedge clk);
        @(negedge clk);
        chk("active_before_reset", 64'(bus.s_valid), 64'h1);
        reset         = 1'b1;
        bus.cpu_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        chk("reset_s_valid", 64'(bus.s_valid), 64'd0);
        chk("reset_cpu_ready", 64'(bus.cpu_ready), 64'd0);
        chk("reset_fault_count", 64'(fault_count), 64'd0);
        chk("reset_fault_addr", 64'(fault_addr), 64'd0);
        m_fcnt  = '0;
        m_faddr = '0;
        repeat (6) begin
            @(negedge clk);
            chk("no_ready_after_reset", 64'(bus.cpu_ready), 64'd0);
        end
        do_txn(32'h1000_0008, 4'h0, 32'h0, 1, 32'hA5A5_0001);

        for (int n = 0; n < 150; n++) begin
            cat = int'($urandom_range(0, 4));
            unique case (cat)
                0: a = 32'h1000_0000 | ($urandom & 32'h0000_000F);
                1: a = 32'h2000_0000 | ($urandom & 32'h0000_00FF);
                2: a = 32'h2000_1000 | ($urandom & 32'h0FFF_FFFF);
                3: a = 32'h3000_0000 | ($urandom & 32'h0000_FFFF);
                default: a = $urandom;
            endcase
            lat = int'($urandom_range(0, 5));
            if (lat == 5) lat = 50;
            do_txn(a, ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0, $urandom, lat,
                   $urandom);
        end

        // Saturation: preload the counter just below the limit.
        @(negedge clk);
        force dut.fault_count_q = 16'hFFFE;
        @(negedge clk);
        release dut.fault_count_q;
        m_fcnt = 16'hFFFE;
        chk("preloaded_count", 64'(fault_count), 64'hFFFE);
        do_txn(32'hF100_0000, 4'h0, 32'h0, 0, 32'h0);
        do_txn(32'hF200_0000, 4'hF, 32'h1, 0, 32'h0);
        do_txn(32'h3000_0040, 4'h0, 32'h0, 50, 32'h0);

        repeat (4) @(negedge clk);
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
